// File: rtl/johnson_decoder_if.sv
// Code-sample and decode-result bundle for johnson_decoder.
// master drives samples, slave returns the decoded step.
interface johnson_decoder_if #(
  parameter int WIDTH = 4,
  localparam int IW = $clog2(2*WIDTH)
);
  logic             code_valid;
  logic [WIDTH-1:0] code_in;
  logic [IW-1:0]    index_out;
  logic             index_valid;
  logic             illegal;
  logic             skip;

  modport master (
    output code_valid, code_in,
    input  index_out, index_valid, illegal, skip
  );

  modport slave (
    input  code_valid, code_in,
    output index_out, index_valid, illegal, skip
  );
endinterface

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes step index, flags illegal
// and skipped steps, tracks lock and a saturating error count.
module johnson_decoder #(
  parameter int WIDTH = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W = 8,
  localparam int IW = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  johnson_decoder_if.slave bus,
  input  logic             err_clr,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_UNLK,
    S_ACQ,
    S_LOCK
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    mcnt, mcnt_n;
  logic [IW-1:0]    prev_q;
  logic [ERR_W-1:0] err_q, err_n;
  logic             iv_q, ill_q, skip_q;
  logic             skip_n, err_ev;

  logic [WIDTH-1:0] lo;
  logic [IW:0]      pop;
  logic [IW:0]      idx_w;
  logic [IW-1:0]    idx;
  logic             legal, seq;

  // Fold the MSB=1 half onto the MSB=0 half before testing.
  always_comb begin
    lo = bus.code_in[WIDTH-1] ? ~bus.code_in : bus.code_in;
    legal = ((lo & (lo + 1'b1)) == '0);
    pop = '0;
    for (int i = 0; i < WIDTH; i++)
      pop = pop + (IW+1)'(bus.code_in[i]);
    idx_w = bus.code_in[WIDTH-1] ? ((IW+1)'(2*WIDTH) - pop) : pop;
    idx = idx_w[IW-1:0];
    if (prev_q == IW'(2*WIDTH-1))
      seq = (idx == '0);
    else
      seq = (idx == prev_q + 1'b1);
  end

  always_comb begin
    state_n = state;
    mcnt_n  = mcnt;
    skip_n  = 1'b0;
    err_ev  = 1'b0;
    if (bus.code_valid) begin
      unique case (state)
        S_UNLK: begin
          if (legal) begin
            state_n = S_ACQ;
            mcnt_n  = CW'(1);
          end
        end
        S_ACQ: begin
          if (!legal) begin
            state_n = S_UNLK;
            mcnt_n  = '0;
          end else if (seq) begin
            mcnt_n = mcnt + 1'b1;
            if (mcnt_n >= CW'(LOCK_COUNT))
              state_n = S_LOCK;
          end else begin
            mcnt_n = CW'(1);
          end
        end
        S_LOCK: begin
          if (!legal) begin
            err_ev  = 1'b1;
            state_n = S_UNLK;
            mcnt_n  = '0;
          end else if (!seq) begin
            skip_n  = 1'b1;
            err_ev  = 1'b1;
            state_n = S_ACQ;
            mcnt_n  = CW'(1);
          end
        end
        default: begin
          state_n = S_UNLK;
          mcnt_n  = '0;
        end
      endcase
    end
  end

  // Clear wins, but a coincident error still counts once.
  always_comb begin
    err_n = err_q;
    if (err_clr)
      err_n = ERR_W'(err_ev);
    else if (err_ev && err_q != '1)
      err_n = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_UNLK;
      mcnt   <= '0;
      prev_q <= '0;
      err_q  <= '0;
      iv_q   <= 1'b0;
      ill_q  <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      state  <= state_n;
      mcnt   <= mcnt_n;
      err_q  <= err_n;
      iv_q   <= bus.code_valid & legal;
      ill_q  <= bus.code_valid & ~legal;
      skip_q <= skip_n;
      if (bus.code_valid && legal)
        prev_q <= idx;
    end
  end

  always_comb begin
    locked          = (state == S_LOCK);
    err_count       = err_q;
    bus.index_out   = prev_q;
    bus.index_valid = iv_q;
    bus.illegal     = ill_q;
    bus.skip        = skip_q;
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder: default instance plus
// an ERR_W=2 instance fed the same stream for saturation.
module tb_johnson_decoder;

  logic       clk;
  logic       reset;
  logic       cv;
  logic [3:0] ci;
  logic       clr;
  logic       lk_a, lk_b;
  logic [7:0] err_a;
  logic [1:0] err_b;

  int n_cmp;
  int n_bad;
  int vn;

  johnson_decoder_if #(.WIDTH(4)) bus_a ();
  johnson_decoder_if #(.WIDTH(4)) bus_b ();

  assign bus_a.code_valid = cv;
  assign bus_a.code_in    = ci;
  assign bus_b.code_valid = cv;
  assign bus_b.code_in    = ci;

  johnson_decoder #(.WIDTH(4), .LOCK_COUNT(4), .ERR_W(8)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a.slave),
    .err_clr   (clr),
    .locked    (lk_a),
    .err_count (err_a)
  );

  johnson_decoder #(.WIDTH(4), .LOCK_COUNT(4), .ERR_W(2)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b.slave),
    .err_clr   (clr),
    .locked    (lk_b),
    .err_count (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input int idx,
                            input int iv, input int ill,
                            input int sk, input int lk,
                            input int err);
    chk({tag, ".idx"}, int'(bus_a.index_out), idx);
    chk({tag, ".iv"}, int'(bus_a.index_valid), iv);
    chk({tag, ".ill"}, int'(bus_a.illegal), ill);
    chk({tag, ".skip"}, int'(bus_a.skip), sk);
    chk({tag, ".lock"}, int'(lk_a), lk);
    chk({tag, ".err"}, int'(err_a), err);
    chk({tag, ".lock_b"}, int'(lk_b), lk);
    chk({tag, ".err_b"}, int'(err_b), (err > 3) ? 3 : err);
  endtask

  task automatic step(input logic v, input logic [3:0] c,
                      input logic cl);
    cv  = v;
    ci  = c;
    clr = cl;
    @(posedge clk);
    #1;
    vn++;
  endtask

  task automatic sv(input logic [3:0] c, input int idx,
                    input int iv, input int ill, input int sk,
                    input int lk, input int err);
    step(1'b1, c, 1'b0);
    expect_out($sformatf("v%0d_c%h", vn, c), idx, iv, ill, sk, lk, err);
  endtask

  task automatic gap(input int idx, input int lk, input int err);
    step(1'b0, 4'h0, 1'b0);
    expect_out($sformatf("gap%0d", vn), idx, 0, 0, 0, lk, err);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vn    = 0;
    reset = 1'b0;
    cv    = 1'b0;
    ci    = 4'h0;
    clr   = 1'b0;
    #12;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    sv(4'h2, 0, 0, 1, 0, 0, 0);
    sv(4'h0, 0, 1, 0, 0, 0, 0);
    sv(4'h1, 1, 1, 0, 0, 0, 0);
    sv(4'h3, 2, 1, 0, 0, 0, 0);
    sv(4'h7, 3, 1, 0, 0, 1, 0);
    sv(4'hF, 4, 1, 0, 0, 1, 0);
    sv(4'hE, 5, 1, 0, 0, 1, 0);
    sv(4'hC, 6, 1, 0, 0, 1, 0);
    sv(4'h8, 7, 1, 0, 0, 1, 0);
    sv(4'h0, 0, 1, 0, 0, 1, 0);
    gap(0, 1, 0);
    sv(4'h1, 1, 1, 0, 0, 1, 0);
    sv(4'h3, 2, 1, 0, 0, 1, 0);
    gap(2, 1, 0);
    sv(4'h7, 3, 1, 0, 0, 1, 0);
    sv(4'hF, 4, 1, 0, 0, 1, 0);
    sv(4'hE, 5, 1, 0, 0, 1, 0);
    sv(4'hC, 6, 1, 0, 0, 1, 0);
    sv(4'h8, 7, 1, 0, 0, 1, 0);

    sv(4'h5, 7, 0, 1, 0, 0, 1);
    sv(4'hF, 4, 1, 0, 0, 0, 1);
    sv(4'hE, 5, 1, 0, 0, 0, 1);
    sv(4'hC, 6, 1, 0, 0, 0, 1);
    sv(4'h8, 7, 1, 0, 0, 1, 1);

    sv(4'h0, 0, 1, 0, 0, 1, 1);
    sv(4'h1, 1, 1, 0, 0, 1, 1);
    sv(4'h3, 2, 1, 0, 0, 1, 1);
    sv(4'h7, 3, 1, 0, 0, 1, 1);
    sv(4'hF, 4, 1, 0, 0, 1, 1);
    sv(4'hC, 6, 1, 0, 1, 0, 2);

    sv(4'h8, 7, 1, 0, 0, 0, 2);
    sv(4'h0, 0, 1, 0, 0, 0, 2);
    sv(4'h1, 1, 1, 0, 0, 1, 2);
    sv(4'h3, 2, 1, 0, 0, 1, 2);
    sv(4'h7, 3, 1, 0, 0, 1, 2);
    sv(4'h7, 3, 1, 0, 1, 0, 3);

    sv(4'hF, 4, 1, 0, 0, 0, 3);
    sv(4'hE, 5, 1, 0, 0, 0, 3);
    sv(4'hC, 6, 1, 0, 0, 1, 3);
    sv(4'hA, 6, 0, 1, 0, 0, 4);
    sv(4'h8, 7, 1, 0, 0, 0, 4);
    sv(4'h0, 0, 1, 0, 0, 0, 4);
    sv(4'h1, 1, 1, 0, 0, 0, 4);
    sv(4'h3, 2, 1, 0, 0, 1, 4);
    sv(4'h0, 0, 1, 0, 1, 0, 5);

    sv(4'h1, 1, 1, 0, 0, 0, 5);
    sv(4'h3, 2, 1, 0, 0, 0, 5);
    sv(4'h7, 3, 1, 0, 0, 1, 5);
    step(1'b1, 4'h9, 1'b1);
    expect_out("clr_ill", 3, 0, 1, 0, 0, 1);
    step(1'b0, 4'h0, 1'b1);
    expect_out("clr_only", 3, 0, 0, 0, 0, 0);

    sv(4'h0, 0, 1, 0, 0, 0, 0);
    sv(4'h1, 1, 1, 0, 0, 0, 0);
    sv(4'h3, 2, 1, 0, 0, 0, 0);
    sv(4'h7, 3, 1, 0, 0, 1, 0);

    cv  = 1'b0;
    clr = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    sv(4'h3, 2, 1, 0, 0, 0, 0);
    sv(4'h7, 3, 1, 0, 0, 0, 0);
    sv(4'hF, 4, 1, 0, 0, 0, 0);
    sv(4'hE, 5, 1, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
- Receive end of the team's 4-bit Johnson counter: samples a Johnson-coded word each valid cycle and decodes it to a binary step index (0..2*WIDTH-1).
- Flags illegal codes and out-of-sequence steps.
- Runs a lock state machine that declares the incoming stream trustworthy after LOCK_COUNT consecutive sequential steps.
- Keeps a saturating error counter.
- Sits beside counter-driven sequencers as a health monitor / phase decoder.

Parameters:
- WIDTH, 4: Johnson word width; legal sequence length is 2*WIDTH.
- LOCK_COUNT, 4: consecutive sequential legal codes required to enter LOCKED (range 2..15).
- ERR_W, 8: width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset=0 resets).
- code_valid  input  1  code_in is sampled on this clock edge.
- code_in  input  WIDTH  Johnson-coded word.
- err_clr  input  1  synchronous clear of err_count.
- index_out  output  IW=$clog2(2*WIDTH)  decoded step index.
- index_valid  output  1  1-cycle pulse: index_out updated from a legal code.
- illegal  output  1  1-cycle pulse: sampled code not a legal Johnson word.
- skip  output  1  1-cycle pulse: legal code, but not predecessor+1 while LOCKED.
- locked  output  1  level, high in LOCKED state.
- err_count  output  ERR_W  saturating count of illegal + skip events.

Behaviour:
- Reset (reset=0, async): index_out=0, index_valid=0, illegal=0, skip=0, locked=0, err_count=0, match_cnt=0, state=UNLOCKED, prev_index=0.
- Legality: code legal iff (code_in[WIDTH-1]=0 and code_in is LSB-aligned ones, i.e. code & (code+1)=0) or (code_in[WIDTH-1]=1 and ~code_in is LSB-aligned ones). For WIDTH=4 the legal set is 0,1,3,7,F,E,C,8; illegal is 2,4,5,6,9,A,B,D.
- Decode: MSB=0 gives index = popcount(code); MSB=1 gives index = WIDTH + count of zeros. For WIDTH=4: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7.
- Latency: all outputs registered; results appear 1 cycle after the sampling edge.
- Pulse outputs are high for exactly one cycle per sampled code.
- code_valid=0: no state, counter or prev_index change; index_valid/illegal/skip = 0; index_out holds.
- Illegal code: index_out and prev_index hold; index_valid=0; illegal=1.
- Sequential: index == (prev_index+1) mod 2*WIDTH, with wrap from 2*WIDTH-1 to 0.
- State UNLOCKED:
  - legal code -> ACQUIRE, match_cnt=1.
  - illegal code -> stay, illegal pulse; err_count not incremented.
- State ACQUIRE:
  - legal and sequential -> match_cnt+1; when it reaches LOCK_COUNT, go to LOCKED (locked=1 on the same registered update).
  - legal and non-sequential, including a repeated code -> match_cnt=1, stay; no skip pulse.
  - illegal -> UNLOCKED, match_cnt=0; illegal pulse; no err_count increment.
- State LOCKED:
  - legal and sequential -> stay.
  - legal and non-sequential, including a repeat -> skip pulse, err_count+1, ACQUIRE with match_cnt=1.
  - illegal -> illegal pulse, err_count+1, UNLOCKED, match_cnt=0.
- err_count:
  - Saturates at 2^ERR_W-1.
  - err_clr has priority: if err_clr and an error occur together, err_count=1.
  - err_clr alone gives err_count=0.
- Reset mid-stream: everything returns to reset values immediately; the first legal code after reset release starts ACQUIRE.
- prev_index is updated on every legal sampled code, in all states.

Test Plan:
- Reset, then feed 0,1,3,7,F,E,C,8,0 each cycle with code_valid=1 -> index 0..7,0 one cycle later.
  - match_cnt reaches 4 on the code 7, giving locked=1 in that output cycle; lock holds through the wrap 8->0.
  - err_count=0.
- While LOCKED, inject 5 -> illegal=1 for 1 cycle, locked=0, err_count=1, index_out holds 7 (the last legal index).
  - Then resume F,E,C,8 -> relock after the 4th legal sequential code.
- While LOCKED after index 3, send F then C (skips E) -> skip=1 on C, err_count+1, locked=0, index_out=6.
  - Repeat-code case: 7,7 -> skip=1 on the second 7.
- Gaps: code_valid toggles 1,0,1 mid-sequence -> no state or err_count change during the gap; lock is maintained across it.
- Saturation, ERR_W=2: force 5 errors -> err_count stays at 3.
  - err_clr coincident with an illegal code while LOCKED -> err_count=1.
- Assert reset=0 asynchronously between clock edges while LOCKED -> outputs clear immediately, without waiting for a clock edge.
  - After release, the first legal code 3 -> index_out=2, state ACQUIRE, locked=0.
